// File: rtl/access_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : access_pkg
//  Purpose  : Shared widths and FSM encodings for the access-code initiator
//             and the access controller it drives.
//  Revision : 1.0  initial release
// ============================================================================
package access_pkg;

    localparam int DIGIT_W     = 4;
    localparam int NUM_DIGITS  = 4;

    // Width of the access controller's state_acc debug port.
    localparam int STATE_ACC_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_GAP    = 3'd2,
        ST_LOGOUT = 3'd3,
        ST_DONE   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/access_code_tx_btn_oneshot.sv
`default_nettype none
// ============================================================================
//  Module   : btn_oneshot
//  Purpose  : N-stage synchronizer for a raw pushbutton followed by a
//             rising-edge detector. pulse_o is high for one cycle per press.
//  Revision : 1.0  initial release
// ============================================================================
module btn_oneshot #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,       // asynchronous, active-low
    input  logic btn_i,
    output logic pulse_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus one flop remembering the last synchronized level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Both operands come straight from flops, so the pulse is glitch-free and
    // lets the top register p_enter on the edge after the level settles.
    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/access_code_tx.sv
`default_nettype none
// ============================================================================
//  Module   : access_code_tx
//  Purpose  : Generates the passnum / p_enter digit stream for the access
//             controller from a manual button, an auto-replayed 4-digit code,
//             or a logout request.
//  Revision : 1.0  initial release
// ============================================================================
module access_code_tx
    import access_pkg::*;
#(
    parameter int GAP_CYCLES  = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,        // asynchronous, active-low
    input  logic                         btn_enter,
    input  logic [DIGIT_W-1:0]           sw_digit,
    input  logic                         auto_start,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] auto_code,
    input  logic                         logout_req,
    output logic [DIGIT_W-1:0]           passnum,
    output logic                         p_enter,
    output logic                         busy,
    output logic [1:0]                   digit_idx,
    output logic                         done
);

    localparam int              CODE_W   = DIGIT_W * NUM_DIGITS;
    localparam logic [3:0]      GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [1:0]      LAST_IDX = 2'(NUM_DIGITS - 1);

    tx_state_t            state_q,   state_d;
    logic [DIGIT_W-1:0]   passnum_q, passnum_d;
    logic                 p_enter_q, p_enter_d;
    logic                 busy_q,    busy_d;
    logic [1:0]           idx_q,     idx_d;
    logic                 done_q,    done_d;
    logic [CODE_W-1:0]    shift_q,   shift_d;
    logic [3:0]           gap_q,     gap_d;

    logic                 btn_pulse;

    btn_oneshot #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_btn_oneshot (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (btn_enter),
        .pulse_o (btn_pulse)
    );

    // State and output registers; every output is driven straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            passnum_q <= '0;
            p_enter_q <= 1'b0;
            busy_q    <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
            shift_q   <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            passnum_q <= passnum_d;
            p_enter_q <= p_enter_d;
            busy_q    <= busy_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
            shift_q   <= shift_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state and next-output logic for request arbitration and sequencing.
    always_comb begin
        state_d   = state_q;
        passnum_d = passnum_q;
        p_enter_d = 1'b0;
        busy_d    = busy_q;
        idx_d     = idx_q;
        done_d    = 1'b0;
        shift_d   = shift_q;
        gap_d     = gap_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // A manual strobe leaves the FSM in IDLE; skipping requests in
                // the cycle it is on the wire keeps p_enter from doubling up.
                if (!p_enter_q) begin
                    if (auto_start) begin
                        state_d   = ST_SEND;
                        passnum_d = auto_code[CODE_W-1 -: DIGIT_W];
                        shift_d   = {auto_code[CODE_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
                        p_enter_d = 1'b1;
                        busy_d    = 1'b1;
                        idx_d     = '0;
                    end else if (logout_req) begin
                        state_d   = ST_LOGOUT;
                        p_enter_d = 1'b1;
                        busy_d    = 1'b1;
                        idx_d     = LAST_IDX;
                    end else if (btn_pulse) begin
                        p_enter_d = 1'b1;
                        passnum_d = sw_digit;
                    end
                end
            end

            ST_SEND, ST_LOGOUT: begin
                state_d = ST_GAP;
                gap_d   = GAP_LOAD;
            end

            ST_GAP: begin
                if (gap_q == 4'd0) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_SEND;
                        idx_d     = idx_q + 2'd1;
                        passnum_d = shift_q[CODE_W-1 -: DIGIT_W];
                        shift_d   = {shift_q[CODE_W-DIGIT_W-1:0], {DIGIT_W{1'b0}}};
                        p_enter_d = 1'b1;
                    end
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign passnum   = passnum_q;
    assign p_enter   = p_enter_q;
    assign busy      = busy_q;
    assign digit_idx = idx_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_access_code_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_access_code_tx
//  Purpose  : Scoreboard bench for access_code_tx. Stimulus pushes expected
//             p_enter pulses and done pulses; a negedge monitor pops them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_access_code_tx;

    localparam int G = 2;   // GAP_CYCLES

    typedef struct {
        logic [3:0] pn;
        logic [1:0] idx;
        logic       has_idx;
        logic       busy;
        int         cyc;
    } pulse_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_enter = 1'b0;
    logic [3:0]  sw_digit = 4'd0;
    logic        auto_start = 1'b0;
    logic [15:0] auto_code = 16'd0;
    logic        logout_req = 1'b0;
    logic [3:0]  passnum;
    logic        p_enter;
    logic        busy;
    logic [1:0]  digit_idx;
    logic        done;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    logic        prev_pe = 1'b0;
    pulse_t      pq[$];
    int          dq[$];

    access_code_tx #(
        .GAP_CYCLES  (G),
        .SYNC_STAGES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_enter  (btn_enter),
        .sw_digit   (sw_digit),
        .auto_start (auto_start),
        .auto_code  (auto_code),
        .logout_req (logout_req),
        .passnum    (passnum),
        .p_enter    (p_enter),
        .busy       (busy),
        .digit_idx  (digit_idx),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Output monitor: every strobe and done pulse must match a queued expectation.
    always @(negedge clk) begin
        pulse_t e;
        if (rst) begin
            if (p_enter) begin
                chk("pe_consecutive", {31'd0, prev_pe}, 32'd0);
                if (pq.size() == 0) begin
                    chk("pe_spurious", {31'd0, p_enter}, 32'd0);
                end else begin
                    e = pq.pop_front();
                    chk("pe_cycle",   cyc,               e.cyc);
                    chk("pe_passnum", {28'd0, passnum},  {28'd0, e.pn});
                    chk("pe_busy",    {31'd0, busy},     {31'd0, e.busy});
                    if (e.has_idx)
                        chk("pe_idx", {30'd0, digit_idx}, {30'd0, e.idx});
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("done_spurious", {31'd0, done}, 32'd0);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                    chk("done_busy",  {31'd0, busy}, 32'd0);
                end
            end
        end
        prev_pe = p_enter;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_pulse(input logic [3:0] pn, input logic [1:0] idx,
                              input logic has_idx, input logic bz, input int c);
        pulse_t p;
        p.pn = pn; p.idx = idx; p.has_idx = has_idx; p.busy = bz; p.cyc = c;
        pq.push_back(p);
    endtask

    // Auto replay; optionally a simultaneous logout and a button press while busy.
    task automatic do_auto(input logic [15:0] code, input logic with_logout,
                           input logic with_btn);
        int a;
        logic [15:0] c;
        c = code;
        auto_code  = code;
        auto_start = 1'b1;
        logout_req = with_logout;
        a = cyc + 1;
        for (int i = 0; i < 4; i++)
            push_pulse(c[15-4*i -: 4], 2'(i), 1'b1, 1'b1, a + i*(G+1));
        dq.push_back(a + 4*(G+1));
        tick(1);
        auto_start = 1'b0;
        logout_req = 1'b0;
        auto_code  = ~code;
        if (with_btn) begin
            sw_digit  = 4'hE;
            btn_enter = 1'b1;
            tick(4);
            btn_enter = 1'b0;
            tick(12);
        end else begin
            tick(16);
        end
        chk("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_manual(input logic [3:0] d, input int hold);
        int a;
        sw_digit  = d;
        btn_enter = 1'b1;
        a = cyc + 1;
        push_pulse(d, 2'd0, 1'b0, 1'b0, a + 2);
        tick(hold);
        btn_enter = 1'b0;
        tick(5);
        chk("manual_hold_passnum", {28'd0, passnum}, {28'd0, d});
    endtask

    initial begin
        int a;
        // Reset state
        tick(3);
        chk("rst_passnum", {28'd0, passnum},  32'd0);
        chk("rst_penter",  {31'd0, p_enter},  32'd0);
        chk("rst_busy",    {31'd0, busy},     32'd0);
        chk("rst_idx",     {30'd0, digit_idx}, 32'd0);
        chk("rst_done",    {31'd0, done},     32'd0);
        rst = 1'b1;
        tick(2);

        // Auto replay of 3153
        do_auto(16'h3153, 1'b0, 1'b0);

        // Logout: single strobe, passnum unchanged at 3
        logout_req = 1'b1;
        a = cyc + 1;
        push_pulse(4'h3, 2'd3, 1'b1, 1'b1, a);
        dq.push_back(a + (G+1));
        tick(1);
        logout_req = 1'b0;
        tick(8);
        chk("logout_passnum", {28'd0, passnum}, 32'h3);

        // Manual presses
        do_manual(4'h4, 6);
        do_manual(4'h5, 6);

        // Simultaneous auto+logout plus button press while busy
        do_auto(16'hA5C7, 1'b1, 1'b1);

        // Asynchronous reset during the second gap
        auto_code  = 16'h3153;
        auto_start = 1'b1;
        a = cyc + 1;
        push_pulse(4'h3, 2'd0, 1'b1, 1'b1, a);
        push_pulse(4'h1, 2'd1, 1'b1, 1'b1, a + (G+1));
        tick(1);
        auto_start = 1'b0;
        tick(G+2);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_passnum", {28'd0, passnum},   32'd0);
        chk("arst_penter",  {31'd0, p_enter},   32'd0);
        chk("arst_busy",    {31'd0, busy},      32'd0);
        chk("arst_idx",     {30'd0, digit_idx}, 32'd0);
        chk("arst_done",    {31'd0, done},      32'd0);
        tick(1);
        rst = 1'b1;
        tick(2);

        // Restart after reset
        do_auto(16'h3453, 1'b0, 1'b0);

        chk("pulse_queue_empty", pq.size(), 32'd0);
        chk("done_queue_empty",  dq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
